accelerator_read_heads: RTL and testbench
=========================================

Name: accelerator_read_heads

Overview:
NTM read-head accelerator: computes the read vector r[k] = sum over j<SIZE_N of w[j]*M[j][k], for k<SIZE_W, from a streamed weighting vector and a streamed memory matrix. It is the reader counterpart of the write-heads block and shares its START/READY handshake and per-element enable/data streaming. One instance sits per read head in the NTM memory subsystem.

Parameters:
DATA_SIZE, 64, width of every data word and size word
CONTROL_SIZE, 4, control field width (reserved, unused here)
N, 64, maximum number of memory rows (weighting buffer depth)
W, 64, maximum number of memory columns (read vector length)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
ACCELERATOR_READ_HEADS_START  in  1  one-cycle start pulse, sampled in IDLE only
ACCELERATOR_READ_HEADS_READY  out  1  one-cycle pulse, operation complete
ACCELERATOR_READ_HEADS_SIZE_N_IN  in  DATA_SIZE  row count, sampled on START
ACCELERATOR_READ_HEADS_SIZE_W_IN  in  DATA_SIZE  column count, sampled on START
ACCELERATOR_READ_HEADS_W_IN_ENABLE  in  1  W_IN valid this cycle
ACCELERATOR_READ_HEADS_W_IN  in  DATA_SIZE  weighting element w[j]
ACCELERATOR_READ_HEADS_M_IN_J_ENABLE  in  1  M_IN valid this cycle (every element)
ACCELERATOR_READ_HEADS_M_IN_K_ENABLE  in  1  marks first element (j=0) of column k
ACCELERATOR_READ_HEADS_M_IN  in  DATA_SIZE  memory element M[j][k]
ACCELERATOR_READ_HEADS_R_OUT_ENABLE  out  1  one-cycle pulse, R_OUT valid
ACCELERATOR_READ_HEADS_R_OUT  out  DATA_SIZE  read element r[k]

Behaviour:
- One clock; reset is asynchronous and active-high. Clock and reset ports are CLK and RST.
- Reset, including mid-operation: FSM to IDLE; READY=0, R_OUT_ENABLE=0, R_OUT=0; counters and accumulator cleared. Weighting buffer contents are don't-care.
- States: IDLE, LOAD_W, READ_M, DONE.
- IDLE:
  - On START, latch sizes. Sizes above N or W are clamped to N or W.
  - If either clamped size is 0: go to DONE, so READY pulses the next cycle and no R_OUT_ENABLE occurs.
  - Otherwise go to LOAD_W with j=0.
- LOAD_W:
  - Each cycle with W_IN_ENABLE=1 writes W_IN to buffer[j] and increments j.
  - After element SIZE_N-1: j=0, k=0, accumulator=0, go to READ_M.
  - M enables are ignored in this state.
- READ_M:
  - Each cycle with M_IN_J_ENABLE=1 does acc = acc + buffer[j]*M_IN and increments j.
  - If K_ENABLE=1 together with J_ENABLE at j!=0: resynchronise. Accumulator restarts with this element as j=0.
  - K_ENABLE without J_ENABLE is ignored. W_IN_ENABLE is ignored.
  - On element j=SIZE_N-1 accepted at cycle t: at t+1, R_OUT = final sum and R_OUT_ENABLE=1 for one cycle. Accumulator and j clear, k increments.
  - Back-to-back columns run with no bubble.
  - After the last column (k=SIZE_W-1), go to DONE.
- DONE: READY=1 for exactly one cycle, coinciding with the last R_OUT_ENABLE pulse (t+1), then return to IDLE. Zero-size case: READY at the cycle after START.
- START outside IDLE is ignored.
- R_OUT holds its last value between pulses.
- Arithmetic:
  - Full 2*DATA_SIZE product; the lower DATA_SIZE bits are accumulated modulo 2^DATA_SIZE.
  - Results are identical under two's-complement interpretation. No saturation, no overflow flag.
- Throughput: one element per cycle. Latency from last element to R_OUT is 1 cycle.

Decomposition:
- Shared package accelerator_ntm_pkg holds:
  - the state enum;
  - localparams for index widths ($clog2(N), $clog2(W));
  - a size-clamp function, reused by the write-heads block.
- One natural sub-module: accelerator_read_heads_mac, a registered multiply-accumulate with clear and load-first inputs.
- The weighting buffer is an inferred array in the top module.

Test Plan:
- SIZE_N=3, SIZE_W=2, w={1,2,3}, M columns {1,1,1},{4,5,6}, elements back-to-back → R_OUT=6 then 32, each with a one-cycle R_OUT_ENABLE; READY coincides with the second pulse.
- SIZE_N=0, SIZE_W=5, START → READY the next cycle, no R_OUT_ENABLE, FSM back in IDLE.
- SIZE_N=2, SIZE_W=1, w={-1,3} (two's complement), M={5,2}, with 1-3 idle cycles between enables → R_OUT=1 (0x…01); gaps do not alter the result.
- Mid-column K_ENABLE: N=3, w={1,1,1}, feed M=7 (j=0), then 9 with K_ENABLE, then 1, 1 → R_OUT=11.
- Assert RST during READ_M after 1 of 2 columns, then a fresh START N=1, W=1, w={4}, M={5} → outputs 0 while in reset, then R_OUT=20 with READY. A second START issued during LOAD_W has no effect.
- Overflow: DATA_SIZE=64, w={2^63}, M={2} → R_OUT=0 (modulo wrap).

Source files
------------

// File: rtl/accelerator_ntm_pkg.sv
// Shared definitions for the NTM read/write head accelerators:
// controller states, default geometry and the size-clamp helper.
package accelerator_ntm_pkg;

    localparam int DATA_SIZE_DEF = 64;
    localparam int N_MAX         = 64;
    localparam int W_MAX         = 64;
    localparam int N_IDX_W       = $clog2(N_MAX);
    localparam int W_IDX_W       = $clog2(W_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        READ_M = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Requested sizes beyond the buffer geometry are limited to it.
    function automatic logic [63:0] clamp_size(input logic [63:0] size, input logic [63:0] limit);
        return (size > limit) ? limit : size;
    endfunction

endpackage

// File: rtl/accelerator_read_heads_mac.sv
// Registered multiply-accumulate, modulo 2^DATA_SIZE, with clear and load-first.
module accelerator_read_heads_mac #(
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 load_first,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    output logic [DATA_SIZE-1:0] sum_next,
    output logic [DATA_SIZE-1:0] acc
);

    // Only the low half of the full product survives the modulo accumulation,
    // so the multiply is evaluated at DATA_SIZE width directly.
    logic [DATA_SIZE-1:0] prod_lo;

    assign prod_lo = a * b;

    always_comb begin
        sum_next = (load_first ? '0 : acc) + prod_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum_next;
        end
    end

endmodule

// File: rtl/accelerator_read_heads.sv
// NTM read head: buffers the weighting vector, then streams memory columns
// and emits r[k] = sum_j w[j]*M[j][k] one cycle after each column's last element.
module accelerator_read_heads
    import accelerator_ntm_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int CONTROL_SIZE = 4,
    parameter int N            = N_MAX,
    parameter int W            = W_MAX
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ACCELERATOR_READ_HEADS_START,
    output logic                 ACCELERATOR_READ_HEADS_READY,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_READ_HEADS_SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_READ_HEADS_SIZE_W_IN,
    input  logic                 ACCELERATOR_READ_HEADS_W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_READ_HEADS_W_IN,
    input  logic                 ACCELERATOR_READ_HEADS_M_IN_J_ENABLE,
    input  logic                 ACCELERATOR_READ_HEADS_M_IN_K_ENABLE,
    input  logic [DATA_SIZE-1:0] ACCELERATOR_READ_HEADS_M_IN,
    output logic                 ACCELERATOR_READ_HEADS_R_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] ACCELERATOR_READ_HEADS_R_OUT,
    output state_t               ACCELERATOR_READ_HEADS_STATE
);

    // Streams are enable-qualified: an element is consumed on every rising
    // edge where its enable is high in the state that accepts it; there is no
    // backpressure, START is a pulse and READY/R_OUT_ENABLE are one-cycle pulses.

    localparam int NCW = $clog2(N + 1);
    localparam int WCW = $clog2(W + 1);
    localparam int NIW = (N > 1) ? $clog2(N) : 1;

    state_t               state, state_next;
    logic [NCW-1:0]       size_n, start_size_n, j_cnt, m_idx;
    logic [WCW-1:0]       size_w, start_size_w, k_cnt;
    logic [DATA_SIZE-1:0] w_buf [N];
    logic [DATA_SIZE-1:0] w_rd, sum_next, acc;
    logic                 w_fire, w_last, m_fire, m_last_j, col_last, ready;

    assign start_size_n = NCW'(clamp_size(64'(ACCELERATOR_READ_HEADS_SIZE_N_IN), 64'(N)));
    assign start_size_w = WCW'(clamp_size(64'(ACCELERATOR_READ_HEADS_SIZE_W_IN), 64'(W)));

    // A K_ENABLE arriving mid-column forces this element back to index 0.
    assign m_idx    = ACCELERATOR_READ_HEADS_M_IN_K_ENABLE ? '0 : j_cnt;
    assign m_last_j = (m_idx == size_n - NCW'(1));
    assign w_last   = (j_cnt == size_n - NCW'(1));
    assign w_rd     = w_buf[m_idx[NIW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ACCELERATOR_READ_HEADS_START) begin
                    if (start_size_n == '0 || start_size_w == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (w_fire && w_last) begin
                    state_next = READ_M;
                end
            end
            READ_M: begin
                if (col_last && k_cnt == size_w - WCW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == DONE);
        w_fire   = (state == LOAD_W) && ACCELERATOR_READ_HEADS_W_IN_ENABLE;
        m_fire   = (state == READ_M) && ACCELERATOR_READ_HEADS_M_IN_J_ENABLE;
        col_last = m_fire && m_last_j;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            size_n <= '0;
            size_w <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
        end else if (state == IDLE && ACCELERATOR_READ_HEADS_START) begin
            size_n <= start_size_n;
            size_w <= start_size_w;
            j_cnt  <= '0;
            k_cnt  <= '0;
        end else if (w_fire) begin
            j_cnt <= w_last ? '0 : j_cnt + NCW'(1);
            k_cnt <= '0;
        end else if (m_fire) begin
            if (m_last_j) begin
                j_cnt <= '0;
                k_cnt <= k_cnt + WCW'(1);
            end else begin
                j_cnt <= m_idx + NCW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fire) begin
            w_buf[j_cnt[NIW-1:0]] <= ACCELERATOR_READ_HEADS_W_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ACCELERATOR_READ_HEADS_R_OUT_ENABLE <= 1'b0;
            ACCELERATOR_READ_HEADS_R_OUT        <= '0;
        end else begin
            ACCELERATOR_READ_HEADS_R_OUT_ENABLE <= col_last;
            if (col_last) begin
                ACCELERATOR_READ_HEADS_R_OUT <= sum_next;
            end
        end
    end

    accelerator_read_heads_mac #(
        .DATA_SIZE(DATA_SIZE)
    ) u_mac (
        .clk        (CLK),
        .rst        (RST),
        .clear      (col_last || (state != READ_M)),
        .enable     (m_fire),
        .load_first (m_idx == '0),
        .a          (w_rd),
        .b          (ACCELERATOR_READ_HEADS_M_IN),
        .sum_next   (sum_next),
        .acc        (acc)
    );

    assign ACCELERATOR_READ_HEADS_READY = ready;
    assign ACCELERATOR_READ_HEADS_STATE = state;

endmodule

// File: tb/tb_accelerator_read_heads.sv
// Directed bench for accelerator_read_heads: hand-computed read vectors,
// handshake timing, resync, reset recovery and modulo wrap.
module tb_accelerator_read_heads;
    import accelerator_ntm_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [DW-1:0] size_n = '0, size_w = '0;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          m_j_en = 1'b0, m_k_en = 1'b0;
    logic [DW-1:0] m_in = '0;
    logic          r_en;
    logic [DW-1:0] r_out;
    state_t        dut_state;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    int            ready_cyc[$];

    accelerator_read_heads dut (
        .CLK                                  (clk),
        .RST                                  (rst),
        .ACCELERATOR_READ_HEADS_START         (start),
        .ACCELERATOR_READ_HEADS_READY         (ready),
        .ACCELERATOR_READ_HEADS_SIZE_N_IN     (size_n),
        .ACCELERATOR_READ_HEADS_SIZE_W_IN     (size_w),
        .ACCELERATOR_READ_HEADS_W_IN_ENABLE   (w_en),
        .ACCELERATOR_READ_HEADS_W_IN          (w_in),
        .ACCELERATOR_READ_HEADS_M_IN_J_ENABLE (m_j_en),
        .ACCELERATOR_READ_HEADS_M_IN_K_ENABLE (m_k_en),
        .ACCELERATOR_READ_HEADS_M_IN          (m_in),
        .ACCELERATOR_READ_HEADS_R_OUT_ENABLE  (r_en),
        .ACCELERATOR_READ_HEADS_R_OUT         (r_out),
        .ACCELERATOR_READ_HEADS_STATE         (dut_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (r_en) begin
            got_q.push_back(r_out);
            got_cyc.push_back(cyc);
        end
        if (ready) ready_cyc.push_back(cyc);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        ready_cyc.delete();
    endtask

    task automatic do_start(input logic [DW-1:0] n, input logic [DW-1:0] w);
        start = 1'b1; size_n = n; size_w = w;
        step();
        start = 1'b0;
    endtask

    task automatic drive_w(input logic [DW-1:0] v);
        w_en = 1'b1; w_in = v;
        step();
        w_en = 1'b0;
    endtask

    task automatic drive_m(input logic [DW-1:0] v, input logic k);
        m_j_en = 1'b1; m_k_en = k; m_in = v;
        step();
        m_j_en = 1'b0; m_k_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_vec++; if (r_en !== 1'b0) begin n_fail++; $display("FAIL reset_r_en got=%b exp=0", r_en); end
        n_vec++; if (r_out !== 64'd0) begin n_fail++; $display("FAIL reset_r_out got=%h exp=0", r_out); end
        n_vec++; if (dut_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut_state, IDLE); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        exp_q.push_back(64'd6);
        exp_q.push_back(64'd32);
        do_start(3, 2);
        drive_w(1); drive_w(2); drive_w(3);
        drive_m(1, 1'b1); drive_m(1, 1'b0); drive_m(1, 1'b0);
        drive_m(4, 1'b1); drive_m(5, 1'b0); drive_m(6, 1'b0);
        n_vec++; if (ready !== 1'b1 || r_en !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_with_last got ready=%b r_en=%b exp 1/1", ready, r_en); end
        step();
        n_vec++; if (dut_state !== IDLE) begin n_fail++; $display("FAIL b2b_state got=%0d exp=%0d", dut_state, IDLE); end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_r_out[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
            if (got_cyc[1] != got_cyc[0] + 3) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=3", got_cyc[1] - got_cyc[0]); end
        end
        n_vec++;
        if (ready_cyc.size() != 1 || got_cyc.size() != 2) begin
            n_fail++; $display("FAIL b2b_ready_count got=%0d exp=1", ready_cyc.size());
        end else if (ready_cyc[0] != got_cyc[1]) begin
            n_fail++; $display("FAIL b2b_ready_cycle got=%0d exp=%0d", ready_cyc[0], got_cyc[1]);
        end
    endtask

    task automatic test_zero_size();
        logic [DW-1:0] ns [2];
        logic [DW-1:0] ws [2];
        ns[0] = 0; ws[0] = 5;
        ns[1] = 4; ws[1] = 0;
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            do_start(ns[t], ws[t]);
            n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL zero%0d_ready got=%b exp=1", t, ready); end
            step();
            n_vec++; if (ready !== 1'b0 || dut_state !== IDLE) begin n_fail++; $display("FAIL zero%0d_after got ready=%b state=%0d exp 0/%0d", t, ready, dut_state, IDLE); end
            idle(2);
            n_vec++; if (got_q.size() != 0 || ready_cyc.size() != 1) begin n_fail++; $display("FAIL zero%0d_pulses got r_en=%0d ready=%0d exp 0/1", t, got_q.size(), ready_cyc.size()); end
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        do_start(2, 1);
        drive_w(64'hFFFF_FFFF_FFFF_FFFF);
        idle($urandom_range(1, 3));
        drive_w(3);
        idle($urandom_range(1, 3));
        drive_m(5, 1'b1);
        idle($urandom_range(1, 3));
        drive_m(2, 1'b0);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd1) begin n_fail++; $display("FAIL gaps_r_out got en=%b val=%h exp 1/1", r_en, r_out); end
        n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL gaps_ready got=%b exp=1", ready); end
        idle(3);
        n_vec++; if (r_out !== 64'd1 || got_q.size() != 1) begin n_fail++; $display("FAIL gaps_hold got val=%h pulses=%0d exp 1/1", r_out, got_q.size()); end
    endtask

    task automatic test_resync();
        clear_mon();
        do_start(3, 1);
        drive_w(1); drive_w(1); drive_w(1);
        drive_m(7, 1'b1);
        drive_m(9, 1'b1);
        drive_m(1, 1'b0);
        n_vec++; if (r_en !== 1'b0) begin n_fail++; $display("FAIL resync_early got=%b exp=0", r_en); end
        drive_m(1, 1'b0);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd11 || ready !== 1'b1) begin n_fail++; $display("FAIL resync_r_out got en=%b val=%0d ready=%b exp 1/11/1", r_en, r_out, ready); end
        step();
    endtask

    task automatic test_reset_mid();
        clear_mon();
        do_start(1, 2);
        drive_w(3);
        drive_m(4, 1'b1);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd12 || dut_state !== READ_M) begin n_fail++; $display("FAIL mid_col0 got en=%b val=%0d state=%0d exp 1/12/%0d", r_en, r_out, dut_state, READ_M); end
        rst = 1'b1;
        #1;
        n_vec++; if (r_en !== 1'b0 || r_out !== 64'd0 || ready !== 1'b0 || dut_state !== IDLE) begin n_fail++; $display("FAIL mid_in_reset got en=%b val=%0d ready=%b state=%0d exp 0/0/0/%0d", r_en, r_out, ready, dut_state, IDLE); end
        step();
        rst = 1'b0;
        idle(1);
        clear_mon();
        do_start(1, 1);
        do_start(3, 3);
        n_vec++; if (dut_state !== LOAD_W) begin n_fail++; $display("FAIL mid_ignore_start got=%0d exp=%0d", dut_state, LOAD_W); end
        drive_w(4);
        drive_m(5, 1'b1);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd20 || ready !== 1'b1) begin n_fail++; $display("FAIL mid_restart got en=%b val=%0d ready=%b exp 1/20/1", r_en, r_out, ready); end
        step();
        n_vec++; if (got_q.size() != 1 || dut_state !== IDLE) begin n_fail++; $display("FAIL mid_after got pulses=%0d state=%0d exp 1/%0d", got_q.size(), dut_state, IDLE); end
    endtask

    task automatic test_overflow();
        clear_mon();
        do_start(1, 1);
        drive_w(64'h8000_0000_0000_0000);
        drive_m(2, 1'b1);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd0) begin n_fail++; $display("FAIL overflow got en=%b val=%h exp 1/0", r_en, r_out); end
        step();
    endtask

    task automatic test_clamp();
        clear_mon();
        do_start(1000, 1);
        for (int j = 0; j < 64; j++) drive_w(1);
        n_vec++; if (dut_state !== READ_M) begin n_fail++; $display("FAIL clamp_load got=%0d exp=%0d", dut_state, READ_M); end
        for (int j = 0; j < 64; j++) drive_m(j, j == 0);
        n_vec++; if (r_en !== 1'b1 || r_out !== 64'd2016 || ready !== 1'b1) begin n_fail++; $display("FAIL clamp_r_out got en=%b val=%0d ready=%b exp 1/2016/1", r_en, r_out, ready); end
        step();
        n_vec++; if (got_q.size() != 1 || ready_cyc.size() != 1) begin n_fail++; $display("FAIL clamp_pulses got r_en=%0d ready=%0d exp 1/1", got_q.size(), ready_cyc.size()); end
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_zero_size();
        test_gaps();
        test_resync();
        test_reset_mid();
        test_overflow();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
